// File: rtl/julia_iterator.sv
// Escape-time engine: one pixel per request, one z <= z^2 + c step per ITER cycle, saturating fixed point.
// Latency N+2 cycles for N updates; in_ready only in IDLE, result held in DONE until out_ready.
module julia_iterator #(
    parameter int WIDTH      = 22,
    parameter int FRACTIONAL = 11,
    parameter int ITER_WIDTH = 8,
    parameter int TAG_WIDTH  = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      px_real,
    input  logic [WIDTH-1:0]      px_imag,
    input  logic [WIDTH-1:0]      c_real,
    input  logic [WIDTH-1:0]      c_imag,
    input  logic [ITER_WIDTH-1:0] max_iter,
    input  logic [TAG_WIDTH-1:0]  tag_in,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ITER_WIDTH-1:0] iter_out,
    output logic                  escaped,
    output logic [TAG_WIDTH-1:0]  tag_out
);

    localparam int PW = 2 * WIDTH;
    localparam int EW = PW + 2;

    localparam logic signed [PW:0]   ESC_LIM = (PW+1)'(4) << (2 * FRACTIONAL);
    localparam logic signed [EW-1:0] SAT_HI  = {{(EW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_LO  = ~SAT_HI;

    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

    state_t                  state;
    logic signed [WIDTH-1:0] zr, zi, cr, ci;
    logic [ITER_WIDTH-1:0]   iter, limit;
    logic [TAG_WIDTH-1:0]    tag;

    logic signed [PW-1:0] p_rr, p_ii, p_ri;
    logic signed [PW:0]   mag;
    logic signed [EW-1:0] nr_w, ni_w;
    logic                 esc_hit;

    assign p_rr = zr * zr;
    assign p_ii = zi * zi;
    assign p_ri = zr * zi;
    assign mag  = (PW+1)'(p_rr) + (PW+1)'(p_ii);
    assign esc_hit = (mag >= ESC_LIM);

    // 2*zr*zi is taken from the exact product, so the doubling costs no precision.
    assign nr_w = EW'(p_rr >>> FRACTIONAL) - EW'(p_ii >>> FRACTIONAL) + EW'(cr);
    assign ni_w = EW'(p_ri >>> (FRACTIONAL - 1)) + EW'(ci);

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [EW-1:0] v);
        if (v > SAT_HI)
            sat = SAT_HI[WIDTH-1:0];
        else if (v < SAT_LO)
            sat = SAT_LO[WIDTH-1:0];
        else
            sat = v[WIDTH-1:0];
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            zr       <= '0;
            zi       <= '0;
            cr       <= '0;
            ci       <= '0;
            iter     <= '0;
            limit    <= '0;
            tag      <= '0;
            iter_out <= '0;
            escaped  <= 1'b0;
            tag_out  <= '0;
        end else if (flush) begin
            if (state != IDLE)
                state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        zr    <= mode ? '0 : px_real;
                        zi    <= mode ? '0 : px_imag;
                        cr    <= mode ? px_real : c_real;
                        ci    <= mode ? px_imag : c_imag;
                        limit <= max_iter;
                        tag   <= tag_in;
                        iter  <= '0;
                        state <= LOAD;
                    end
                end
                // Load cycle keeps the input muxes out of the multiplier cone.
                LOAD: state <= ITER;
                ITER: begin
                    if (esc_hit) begin
                        iter_out <= iter;
                        escaped  <= 1'b1;
                        tag_out  <= tag;
                        state    <= DONE;
                    end else if (iter == limit) begin
                        iter_out <= iter;
                        escaped  <= 1'b0;
                        tag_out  <= tag;
                        state    <= DONE;
                    end else begin
                        zr   <= sat(nr_w);
                        zi   <= sat(ni_w);
                        iter <= iter + ITER_WIDTH'(1);
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
